mult_arbiter_seq: RTL
=====================

MULT_ARBITER_SEQ -- requirements
Module: mult_arbiter_seq

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 selects round-robin arbitration, 1 selects fixed priority with requester 0 highest.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_0  input  1  requester 0 multiply request.
REQ-005 opa_0  input  3  requester 0 multiplicand, unsigned.
REQ-006 opb_0  input  3  requester 0 multiplier, unsigned.
REQ-007 req_1  input  1  requester 1 multiply request.
REQ-008 opa_1  input  3  requester 1 multiplicand, unsigned.
REQ-009 opb_1  input  3  requester 1 multiplier, unsigned.
REQ-010 grant  output  2  one-hot owner of the shared multiplier; bit i set for requester i.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  single-cycle completion strobe.
REQ-013 done_id  output  1  index of the requester whose result is on product.
REQ-014 product  output  6  unsigned product opa*opb, range 0..49.
REQ-015 bcd_tens  output  4  decimal tens digit of product.
REQ-016 bcd_ones  output  4  decimal ones digit of product.

Function
REQ-017 FSM states: IDLE, CALC, DONE; a 2-bit step counter runs 0..2 inside CALC.
REQ-018 IDLE with no request: stay in IDLE; grant=00; busy=0.
REQ-019 IDLE with any request sampled at an edge:
  - pick the winner per REQ-020/021;
  - latch the winner's opa and opb;
  - clear the accumulator and the step counter;
  - set grant to the winner;
  - go to CALC.
REQ-020 Round-robin (FIXED_PRIO=0):
  - one request pending: that requester wins;
  - both pending: the requester not served last wins;
  - the last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-021 Fixed priority (FIXED_PRIO=1): requester 0 wins whenever req_0 is high.
REQ-022 CALC, shift-add, one step per cycle:
  - at step i, if latched opb[i]=1 then acc <= acc + (opa << i);
  - the accumulator is 6 bits wide and never overflows.
REQ-023 After step 2, go to DONE; CALC therefore lasts exactly 3 cycles.
REQ-024 DONE lasts one cycle:
  - done=1;
  - done_id = winner;
  - product, bcd_tens and bcd_ones are valid;
  - update the last-served pointer;
  - next state IDLE.
REQ-025 Latency: request sampled at edge N; grant and busy high in cycles N+1..N+4; done high in cycle N+4 only.
REQ-026 Back-to-back requests: at least one IDLE cycle between operations; the next grant is decided in that IDLE cycle.
REQ-027 Operands are latched once, in IDLE; operand or req changes during CALC/DONE have no effect.
REQ-028 Dropping req mid-operation does not abort it; the operation completes and done still pulses.
REQ-029 bcd_tens = product/10 and bcd_ones = product mod 10; both are registered with product at entry to DONE.
REQ-030 product, bcd_tens, bcd_ones and done_id hold their values until the next DONE.
REQ-031 The losing requester must keep req high to be served later; no request is queued internally.

Reset
REQ-032 When rst=1 at a clock edge, on that edge:
  - state=IDLE;
  - grant=00, busy=0, done=0, done_id=0;
  - product=0, bcd_tens=0, bcd_ones=0;
  - accumulator and step counter = 0;
  - last-served pointer = 1.
REQ-033 rst takes precedence in every state; an operation interrupted by reset produces no done strobe.

Verification
REQ-034 Reset: hold rst for 2 cycles -> every output 0 and grant=00.
REQ-035 req_0 alone, 7x7, sampled at edge N -> grant=01 in N+1..N+4; done in N+4 only; product=49, tens=4, ones=9, done_id=0.
REQ-036 Round-robin, both requests held from reset release, req_0 = 2x4, req_1 = 4x6 -> req_0 served first (product=8, tens=0, ones=8); one IDLE cycle; then req_1 served (product=24, tens=2, ones=4, done_id=1); then req_0 again.
REQ-037 FIXED_PRIO=1, both requests held -> every done has done_id=0; grant never equals 10.
REQ-038 rst pulsed in the 2nd CALC cycle -> IDLE on the next cycle; busy=0; product=0; no done strobe; a fresh request then completes normally.
REQ-039 Zero operand, req_1 = 0x5 -> product=0, tens=0, ones=0, done_id=1.

Source files
------------

// File: rtl/mult_arbiter_seq.sv
// Two-requester arbiter in front of one 3x3-bit shift-add multiplier.
// Each operation takes three CALC steps, then one DONE cycle that holds the result and its BCD split.
module mult_arbiter_seq #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_0,
    input  logic [2:0] opa_0,
    input  logic [2:0] opb_0,
    input  logic       req_1,
    input  logic [2:0] opa_1,
    input  logic [2:0] opb_1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [5:0] product,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [5:0] acc_q, acc_d;
    logic [2:0] opa_q, opa_d;
    logic [2:0] opb_q, opb_d;
    logic       winner_q, winner_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       done_id_q, done_id_d;
    logic [5:0] product_q, product_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    logic       pick;
    logic [5:0] addend;
    logic [5:0] acc_sum;
    logic [3:0] tens_w;
    logic [5:0] base_w;
    logic [3:0] ones_w;

    // With both pending, round-robin favours whoever was not served last.
    always_comb begin
        pick = 1'b0;
        if (FIXED_PRIO)
            pick = !req_0;
        else if (req_0 && req_1)
            pick = !last_q;
        else
            pick = req_1;
    end

    always_comb begin
        addend = 6'd0;
        case (step_q)
            2'd0:    addend = opb_q[0] ? {3'b000, opa_q}       : 6'd0;
            2'd1:    addend = opb_q[1] ? {2'b00, opa_q, 1'b0}  : 6'd0;
            2'd2:    addend = opb_q[2] ? {1'b0, opa_q, 2'b00}  : 6'd0;
            default: addend = 6'd0;
        endcase
        acc_sum = acc_q + addend;
    end

    // Product never exceeds 49, so the tens digit is at most 4.
    always_comb begin
        tens_w = 4'd0;
        base_w = 6'd0;
        if (acc_sum >= 6'd40) begin
            tens_w = 4'd4;
            base_w = 6'd40;
        end else if (acc_sum >= 6'd30) begin
            tens_w = 4'd3;
            base_w = 6'd30;
        end else if (acc_sum >= 6'd20) begin
            tens_w = 4'd2;
            base_w = 6'd20;
        end else if (acc_sum >= 6'd10) begin
            tens_w = 4'd1;
            base_w = 6'd10;
        end
        ones_w = 4'(acc_sum - base_w);
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        winner_d  = winner_q;
        last_d    = last_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        product_d = product_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                if (req_0 || req_1) begin
                    winner_d = pick;
                    opa_d    = pick ? opa_1 : opa_0;
                    opb_d    = pick ? opb_1 : opb_0;
                    acc_d    = 6'd0;
                    step_d   = 2'd0;
                    grant_d  = pick ? 2'b10 : 2'b01;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                if (step_q == 2'd2) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = winner_q;
                    product_d = acc_sum;
                    tens_d    = tens_w;
                    ones_d    = ones_w;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            DONE: begin
                last_d  = winner_q;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= 2'd0;
            acc_q     <= 6'd0;
            opa_q     <= 3'd0;
            opb_q     <= 3'd0;
            winner_q  <= 1'b0;
            last_q    <= 1'b1;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            product_q <= 6'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            product_q <= product_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign product  = product_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;

endmodule
